// File: rtl/x2c_pkt_buf.sv
// x2c_pkt_buf: packet buffer with commit/rewind data FIFO and byte-count FIFO
// Ports:
//   clk, reset_        single clock, asynchronous active-low reset
//   linkup             link-good; while low, partial packets are discarded
//   x_we, data_in, ctrl_in        write one 256-bit data + 32-bit ctrl word
//   x_bcnt_we, x_byte_cnt         end-of-packet commit with {sof, 0, byte count}
//   dat_rd, dat_out, ctl_out, dat_vld     data pop, result one cycle later
//   bcnt_rd, bcnt_out, bcnt_vld           byte-count pop, result one cycle later
//   dat_empty, bcnt_empty, pkt_cnt, drop_cnt  registered status
module x2c_pkt_buf #(
    parameter int DAT_AW  = 4,
    parameter int BCNT_AW = 3
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic               linkup,
    input  logic               x_we,
    input  logic [255:0]       data_in,
    input  logic [31:0]        ctrl_in,
    input  logic               x_bcnt_we,
    input  logic [31:0]        x_byte_cnt,
    input  logic               dat_rd,
    input  logic               bcnt_rd,
    output logic [255:0]       dat_out,
    output logic [31:0]        ctl_out,
    output logic               dat_vld,
    output logic [31:0]        bcnt_out,
    output logic               bcnt_vld,
    output logic               dat_empty,
    output logic               bcnt_empty,
    output logic [BCNT_AW:0]   pkt_cnt,
    output logic [15:0]        drop_cnt
);
    logic [287:0]      dmem [1<<DAT_AW];
    logic [31:0]       bmem [1<<BCNT_AW];
    logic [DAT_AW:0]   wr_ptr, commit_ptr, rd_ptr, wr_nxt, commit_nxt, rd_nxt, wr_inc;
    logic [BCNT_AW:0]  bw_ptr, br_ptr, bw_nxt, br_nxt;
    logic              drop_flag, drop_nxt, rst_q1, rst_n;
    logic              dat_full, bcnt_full, word_ok, commit, bad, good, dat_pop, bcnt_pop;

    // Reset asserts immediately but releases only on a clk edge.
    always_ff @(posedge clk or negedge reset_)
        if (!reset_) {rst_n, rst_q1} <= 2'b00;
        else         {rst_n, rst_q1} <= {rst_q1, 1'b1};

    always_comb begin
        dat_full   = (wr_ptr - rd_ptr) == {1'b1, {DAT_AW{1'b0}}};
        bcnt_full  = (bw_ptr - br_ptr) == {1'b1, {BCNT_AW{1'b0}}};
        word_ok    = x_we & linkup & !dat_full & !drop_flag;
        wr_inc     = wr_ptr + {{DAT_AW{1'b0}}, word_ok};
        commit     = x_bcnt_we & linkup;
        // A same-cycle word that cannot be stored would truncate the packet.
        bad        = drop_flag | bcnt_full | (x_byte_cnt[15:0] == 16'd0) | (x_we & !word_ok);
        good       = commit & !bad;
        dat_pop    = dat_rd & !dat_empty;
        bcnt_pop   = bcnt_rd & !bcnt_empty;
        wr_nxt     = (!linkup || (commit && bad)) ? commit_ptr : wr_inc;
        commit_nxt = good ? wr_inc : commit_ptr;
        rd_nxt     = rd_ptr + {{DAT_AW{1'b0}}, dat_pop};
        bw_nxt     = bw_ptr + {{BCNT_AW{1'b0}}, good};
        br_nxt     = br_ptr + {{BCNT_AW{1'b0}}, bcnt_pop};
        drop_nxt   = (!linkup || x_bcnt_we) ? 1'b0 : (drop_flag | (x_we & dat_full));
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            bw_ptr     <= '0;
            br_ptr     <= '0;
            drop_flag  <= 1'b0;
            dat_out    <= '0;
            ctl_out    <= '0;
            bcnt_out   <= '0;
            dat_vld    <= 1'b0;
            bcnt_vld   <= 1'b0;
            dat_empty  <= 1'b1;
            bcnt_empty <= 1'b1;
            pkt_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            wr_ptr     <= wr_nxt;
            commit_ptr <= commit_nxt;
            rd_ptr     <= rd_nxt;
            bw_ptr     <= bw_nxt;
            br_ptr     <= br_nxt;
            drop_flag  <= drop_nxt;
            // Status is computed from next-state pointers so it always matches them.
            dat_empty  <= rd_nxt == commit_nxt;
            bcnt_empty <= br_nxt == bw_nxt;
            pkt_cnt    <= bw_nxt - br_nxt;
            if (commit && bad && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            dat_vld    <= dat_pop;
            bcnt_vld   <= bcnt_pop;
            if (dat_pop) {ctl_out, dat_out} <= dmem[rd_ptr[DAT_AW-1:0]];
            if (bcnt_pop) bcnt_out <= bmem[br_ptr[BCNT_AW-1:0]];
        end

    always_ff @(posedge clk) begin
        if (word_ok) dmem[wr_ptr[DAT_AW-1:0]] <= {ctrl_in, data_in};
        if (good) bmem[bw_ptr[BCNT_AW-1:0]] <= x_byte_cnt;
    end
endmodule

// File: tb/tb_x2c_pkt_buf.sv
// tb_x2c_pkt_buf: directed scoreboard bench for x2c_pkt_buf
module tb_x2c_pkt_buf;
    logic         clk = 1'b0, reset_ = 1'b1, linkup = 1'b1;
    logic         x_we = 1'b0, x_bcnt_we = 1'b0, dat_rd = 1'b0, bcnt_rd = 1'b0;
    logic [255:0] data_in = '0;
    logic [31:0]  ctrl_in = '0, x_byte_cnt = '0;
    logic [255:0] dat_out;
    logic [31:0]  ctl_out, bcnt_out;
    logic         dat_vld, bcnt_vld, dat_empty, bcnt_empty;
    logic [3:0]   pkt_cnt;
    logic [15:0]  drop_cnt;
    int           errors = 0, checks = 0;
    logic [287:0] exp_dat [$];
    logic [31:0]  exp_bc [$];
    logic [287:0] w0, w1, w2;

    x2c_pkt_buf #(.DAT_AW(4), .BCNT_AW(3)) dut (
        .clk(clk), .reset_(reset_), .linkup(linkup), .x_we(x_we), .data_in(data_in),
        .ctrl_in(ctrl_in), .x_bcnt_we(x_bcnt_we), .x_byte_cnt(x_byte_cnt), .dat_rd(dat_rd),
        .bcnt_rd(bcnt_rd), .dat_out(dat_out), .ctl_out(ctl_out), .dat_vld(dat_vld),
        .bcnt_out(bcnt_out), .bcnt_vld(bcnt_vld), .dat_empty(dat_empty),
        .bcnt_empty(bcnt_empty), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [287:0] rnd();
        logic [287:0] r;
        for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock of stimulus; any pop result is checked against the scoreboard.
    task automatic cyc(input logic we, input logic [287:0] w, input logic bwe,
                       input logic [31:0] bc, input logic drd, input logic brd);
        logic dv_exp, bv_exp;
        dv_exp = drd && exp_dat.size() > 0;
        bv_exp = brd && exp_bc.size() > 0;
        x_we = we;
        {ctrl_in, data_in} = w;
        x_bcnt_we = bwe;
        x_byte_cnt = bc;
        dat_rd = drd;
        bcnt_rd = brd;
        @(posedge clk);
        #1;
        x_we = 1'b0;
        x_bcnt_we = 1'b0;
        dat_rd = 1'b0;
        bcnt_rd = 1'b0;
        if (drd) begin
            chk("dat_vld", dat_vld, dv_exp);
            if (dv_exp) chk("dat_word", {ctl_out, dat_out}, exp_dat.pop_front());
        end
        if (brd) begin
            chk("bcnt_vld", bcnt_vld, bv_exp);
            if (bv_exp) chk("bcnt_out", bcnt_out, exp_bc.pop_front());
        end
    endtask

    task automatic send_pkt(input int n, input logic [31:0] bc, input logic good, input logic rd);
        logic [287:0] q [$];
        logic [287:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd();
            q.push_back(w);
            cyc(1'b1, w, i == n - 1, bc, rd, rd && i == n - 1);
        end
        if (good) begin
            foreach (q[i]) exp_dat.push_back(q[i]);
            exp_bc.push_back(bc);
        end
    endtask

    task automatic drain(input string tag);
        while (exp_bc.size() > 0) cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        while (exp_dat.size() > 0) cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        chk({tag, " dat_empty"}, dat_empty, 1'b1);
        chk({tag, " bcnt_empty"}, bcnt_empty, 1'b1);
        chk({tag, " pkt_cnt"}, pkt_cnt, 4'd0);
    endtask

    // Asserts reset off a clock edge and checks outputs before any edge arrives.
    task automatic do_reset();
        #3 reset_ = 1'b0;
        #2;
        chk("rst dat_empty", dat_empty, 1'b1);
        chk("rst bcnt_empty", bcnt_empty, 1'b1);
        chk("rst pkt_cnt", pkt_cnt, 4'd0);
        chk("rst drop_cnt", drop_cnt, 16'd0);
        chk("rst vld", {dat_vld, bcnt_vld}, 2'b00);
        chk("rst dat_out", {ctl_out, dat_out}, '0);
        chk("rst bcnt_out", bcnt_out, 32'd0);
        exp_dat.delete();
        exp_bc.delete();
        linkup = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_ = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        do_reset();
        // Basic 3-word packet, commit alongside the last word
        w0 = rnd();
        w1 = rnd();
        w2 = rnd();
        cyc(1'b1, w0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, w1, 1'b0, '0, 1'b0, 1'b0);
        chk("uncommitted hidden", dat_empty, 1'b1);
        cyc(1'b1, w2, 1'b1, 32'h0100_0060, 1'b0, 1'b0);
        exp_dat.push_back(w0);
        exp_dat.push_back(w1);
        exp_dat.push_back(w2);
        exp_bc.push_back(32'h0100_0060);
        chk("t1 bcnt_empty", bcnt_empty, 1'b0);
        chk("t1 pkt_cnt", pkt_cnt, 4'd1);
        chk("t1 dat_empty", dat_empty, 1'b0);
        drain("t1");
        cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        chk("empty read dat hold", {ctl_out, dat_out}, w2);
        chk("empty read bcnt hold", bcnt_out, 32'h0100_0060);
        // Data FIFO overflow mid-packet
        do_reset();
        repeat (7) send_pkt(2, 32'h0000_0040, 1'b1, 1'b0);
        chk("t2 pkt_cnt before", pkt_cnt, 4'd7);
        send_pkt(4, 32'h0000_0080, 1'b0, 1'b0);
        chk("t2 drop_cnt", drop_cnt, 16'd1);
        chk("t2 pkt_cnt after", pkt_cnt, 4'd7);
        drain("t2");
        // Byte-count FIFO full, then zero byte count
        do_reset();
        repeat (8) send_pkt(1, 32'h0000_0020, 1'b1, 1'b0);
        chk("t3 pkt_cnt full", pkt_cnt, 4'd8);
        send_pkt(1, 32'h0000_0020, 1'b0, 1'b0);
        chk("t3 drop_cnt", drop_cnt, 16'd1);
        chk("t3 pkt_cnt kept", pkt_cnt, 4'd8);
        cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        send_pkt(1, 32'h0200_0010, 1'b1, 1'b0);
        chk("t3 tenth pkt_cnt", pkt_cnt, 4'd8);
        chk("t3 tenth drop_cnt", drop_cnt, 16'd1);
        drain("t3");
        send_pkt(2, 32'h0300_0000, 1'b0, 1'b0);
        chk("zero bcnt drop_cnt", drop_cnt, 16'd2);
        chk("zero bcnt dat_empty", dat_empty, 1'b1);
        // Link loss mid-packet
        do_reset();
        cyc(1'b1, rnd(), 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, rnd(), 1'b0, '0, 1'b0, 1'b0);
        linkup = 1'b0;
        cyc(1'b1, rnd(), 1'b1, 32'h0000_0010, 1'b0, 1'b0);
        cyc(1'b1, rnd(), 1'b0, '0, 1'b0, 1'b0);
        linkup = 1'b1;
        chk("t4 linkdown empty", dat_empty, 1'b1);
        send_pkt(1, 32'h0100_0008, 1'b1, 1'b0);
        chk("t4 pkt_cnt", pkt_cnt, 4'd1);
        chk("t4 drop_cnt", drop_cnt, 16'd0);
        drain("t4");
        // Streaming with concurrent reads across pointer wrap
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send_pkt(3, {i[7:0], 8'h00, 16'(3 * i + 3)}, 1'b1, 1'b1);
            chk("t5 pkt_cnt", pkt_cnt, exp_bc.size());
        end
        chk("t5 drop_cnt", drop_cnt, 16'd0);
        drain("t5");
        // Asynchronous reset in the middle of a packet
        send_pkt(1, 32'h0000_0000, 1'b0, 1'b0);
        chk("t6 pre drop_cnt", drop_cnt, 16'd1);
        cyc(1'b1, rnd(), 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, rnd(), 1'b0, '0, 1'b0, 1'b0);
        do_reset();
        send_pkt(2, 32'h0100_0004, 1'b1, 1'b0);
        chk("t6 pkt_cnt", pkt_cnt, 4'd1);
        drain("t6");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/x2c_pkt_buf.md
X2C_PKT_BUF -- requirements
Module: x2c_pkt_buf

Interface
REQ-001 SHALL have parameter DAT_AW, default 4, meaning log2 of data/ctrl FIFO depth (16 entries of 288 bits).
REQ-002 SHALL have parameter BCNT_AW, default 3, meaning log2 of byte-count FIFO depth (8 entries of 32 bits).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; one clock, no clock-domain crossing.
REQ-004 SHALL have port reset_, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port linkup, input, 1 bit: link-good indication from the serial-to-parallel stage.
REQ-006 SHALL have port x_we, input, 1 bit: write strobe for one 256-bit data word and its 32-bit ctrl word.
REQ-007 SHALL have ports data_in, input, 256 bits, and ctrl_in, input, 32 bits: the word being written.
REQ-008 SHALL have port x_bcnt_we, input, 1 bit: end-of-packet commit strobe.
REQ-009 SHALL have port x_byte_cnt, input, 32 bits: {sof flags[31:24], 0[23:16], byte count[15:0]}.
REQ-010 SHALL have ports dat_rd, input, 1 bit, and bcnt_rd, input, 1 bit: consumer pop requests.
REQ-011 SHALL have ports dat_out, output, 256 bits; ctl_out, output, 32 bits; dat_vld, output, 1 bit: popped data word.
REQ-012 SHALL have ports bcnt_out, output, 32 bits, and bcnt_vld, output, 1 bit: popped byte-count entry.
REQ-013 SHALL have ports dat_empty, output, 1 bit; bcnt_empty, output, 1 bit; pkt_cnt, output, BCNT_AW+1 bits: occupancy status.
REQ-014 SHALL have port drop_cnt, output, 16 bits: count of dropped packets.

Function
REQ-015 SHALL use wr_ptr, commit_ptr and rd_ptr for data, each DAT_AW+1 bits wide, with the MSB distinguishing full from empty and natural wrap-around.
REQ-016 SHALL store a word on x_we & linkup & !full & !drop_flag, writing at wr_ptr and then incrementing wr_ptr; full means wr_ptr-rd_ptr == 2^DAT_AW.
REQ-017 SHALL set drop_flag and store nothing when x_we arrives while full; drop_flag SHALL persist until the next x_bcnt_we.
REQ-018 SHALL treat a word written in the same cycle as x_bcnt_we as the last word of the committing packet.
REQ-019 SHALL drop the packet on x_bcnt_we when any of the following holds: drop_flag set, byte-count FIFO full, x_byte_cnt[15:0]==0, or a same-cycle word cannot be stored.
REQ-020 SHALL, on drop, rewind wr_ptr to commit_ptr, leave the byte-count FIFO unchanged, clear drop_flag, and increment drop_cnt, saturating at 0xFFFF.
REQ-021 SHALL, on a good commit, set commit_ptr to the post-write wr_ptr, push x_byte_cnt, and clear drop_flag.
REQ-022 SHALL, while linkup=0, ignore x_we and x_bcnt_we, set wr_ptr to commit_ptr, clear drop_flag, and leave committed packets readable; these discards SHALL NOT increment drop_cnt.
REQ-023 SHALL derive dat_empty as (rd_ptr == commit_ptr), so uncommitted words are never visible to the consumer.
REQ-024 SHALL, on dat_rd & !dat_empty, increment rd_ptr; dat_out/ctl_out SHALL update and dat_vld SHALL pulse high on the next cycle (one-cycle latency).
REQ-025 SHALL, on bcnt_rd & !bcnt_empty, pop identically, with bcnt_out and bcnt_vld following one cycle later.
REQ-026 SHALL treat any read while empty as a no-op: no pointer change, vld stays 0, outputs hold.
REQ-027 SHALL register all status outputs and update them the cycle after the causing event; pkt_cnt SHALL equal the byte-count FIFO occupancy.
REQ-028 SHALL handle a simultaneous commit and pop in the same cycle: occupancy net unchanged, no lost entry.

Reset
REQ-029 SHALL, while reset_=0 (asynchronous assert, synchronous deassert by clk), set all pointers 0, drop_flag 0, dat_out/ctl_out/bcnt_out 0, dat_vld/bcnt_vld 0, dat_empty/bcnt_empty 1, pkt_cnt 0, and drop_cnt 0.
REQ-030 SHALL NOT reset the storage arrays.

Verification
REQ-031 SHALL cover this case: linkup=1; 3 words A,B,C written, with x_bcnt_we and x_byte_cnt=0x0100_0060 issued alongside C. Required: bcnt_empty=0 and pkt_cnt=1 one cycle later; bcnt_rd gives bcnt_out=0x0100_0060; 3 dat_rd give A,B,C in order; dat_empty=1 after the pops.
REQ-032 SHALL cover this case: 14 words committed and unread, then a 4-word packet arrives. Required: words 3 and 4 are not stored; the commit drops; drop_cnt=1; pkt_cnt unchanged; exactly 14 words are readable.
REQ-033 SHALL cover this case: 8 one-word packets committed, then a 9th arrives. Required: the 9th is dropped; drop_cnt=1; pkt_cnt=8; after one bcnt_rd plus one dat_rd, a 10th packet commits normally.
REQ-034 SHALL cover this case: linkup drops to 0 after 2 words of a packet, then returns to 1 and a 1-word packet commits. Required: only the 1-word packet is readable; drop_cnt=0.
REQ-035 SHALL cover this case: 40 packets of 3 words each, with interleaved reads across pointer wrap. Required: every word and byte-count entry is returned in order, with no drops.
REQ-036 SHALL cover this case: reset_ asserted mid-packet, asynchronously and off a clk edge. Required: outputs immediately take their REQ-029 values; after release, a new packet commits and reads back correctly.
